// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared op/state encodings for the multiply/divide unit (MULDIV_SIGNED_EN adds FIXUP)
package ex_muldiv_pkg;

   localparam int ITER_COUNT    = 32;
   localparam int OP_DIV_BIT    = 0;
   localparam int OP_SIGNED_BIT = 1;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MULT  = 2'b10,
      OP_DIV   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
`ifdef MULDIV_SIGNED_EN
      FIXUP = 2'd2,
`endif
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ex_muldiv_iter.sv
// rtl/ex_muldiv_iter.sv - one-bit-per-cycle shift-add multiply / restoring divide datapath
module ex_muldiv_iter #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           load,
   input  logic           step,
   input  logic           is_div,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] acc,
   output logic [2*W-1:0] acc_nxt
);

   logic [W-1:0] divr;
   logic [W:0]   sum;
   logic [W:0]   rem_sh;
   logic [W:0]   diff;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, divr} : {(W+1){1'b0}});
      rem_sh = acc[2*W-1:W-1];
      diff   = rem_sh - {1'b0, divr};
      if (!is_div)
         acc_nxt = {sum, acc[W-1:1]};
      else if (diff[W])
         acc_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
      else
         acc_nxt = {diff[W-1:0], acc[W-2:0], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc  <= '0;
         divr <= '0;
      end else if (load) begin
         acc  <= {{W{1'b0}}, a};
         divr <= b;
      end else if (step) begin
         acc  <= acc_nxt;
      end
   end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - multiply/divide control: FSM, counter, HI/LO; MULDIV_SIGNED_EN enables MULT/DIV
module ex_muldiv_ctrl
   import ex_muldiv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start_EX,
   input  logic [1:0]        Op_EX,
   input  logic [DATA_W-1:0] Operand_A_EX,
   input  logic [DATA_W-1:0] Operand_B_EX,
   input  logic              Mf_Req_EX,
   output logic              Busy_EX,
   output logic              Stall_EX,
   output logic              Done_EX,
   output logic              Div_By_Zero_EX,
   output logic [DATA_W-1:0] HI_EX,
   output logic [DATA_W-1:0] LO_EX
);

   localparam logic [5:0] LAST = 6'(ITER_COUNT - 1);

   state_t              state, state_nxt;
   logic [5:0]          count;
   logic                is_div, div_zero;
   logic                load, step, wr_res;
   logic [DATA_W-1:0]   opa, opb, hi_nxt, lo_nxt;
   logic [2*DATA_W-1:0] acc, acc_nxt;

`ifdef MULDIV_SIGNED_EN
   logic signed_req, op_signed, neg_lo, neg_hi;
   assign signed_req = Op_EX[OP_SIGNED_BIT];
   assign opa = (signed_req && Operand_A_EX[DATA_W-1]) ? -Operand_A_EX : Operand_A_EX;
   assign opb = (signed_req && Operand_B_EX[DATA_W-1]) ? -Operand_B_EX : Operand_B_EX;
`else
   logic unused_sig;
   assign unused_sig = Op_EX[OP_SIGNED_BIT] ^ (^acc);
   assign opa = Operand_A_EX;
   assign opb = Operand_B_EX;
`endif

   ex_muldiv_iter #(.W(DATA_W)) u_iter (
      .clk     (Clk),
      .reset_n (Reset_n),
      .load    (load),
      .step    (step),
      .is_div  (is_div),
      .a       (opa),
      .b       (opb),
      .acc     (acc),
      .acc_nxt (acc_nxt)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      wr_res    = 1'b0;
      hi_nxt    = acc_nxt[2*DATA_W-1:DATA_W];
      lo_nxt    = acc_nxt[DATA_W-1:0];
      case (state)
         IDLE, DONE: begin
            load      = Start_EX;
            state_nxt = Start_EX ? RUN : IDLE;
         end
         RUN: begin
            step = 1'b1;
            if (count == LAST) begin
               state_nxt = DONE;
               wr_res    = 1'b1;
`ifdef MULDIV_SIGNED_EN
               if (op_signed) begin
                  state_nxt = FIXUP;
                  wr_res    = 1'b0;
               end
`endif
            end
         end
`ifdef MULDIV_SIGNED_EN
         FIXUP: begin
            wr_res    = 1'b1;
            state_nxt = DONE;
            if (is_div) begin
               hi_nxt = neg_hi ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
               lo_nxt = neg_lo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
            end else begin
               {hi_nxt, lo_nxt} = neg_lo ? -acc : acc;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state    <= IDLE;
         count    <= '0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         HI_EX    <= '0;
         LO_EX    <= '0;
`ifdef MULDIV_SIGNED_EN
         op_signed <= 1'b0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (load) begin
            count    <= '0;
            is_div   <= Op_EX[OP_DIV_BIT];
            div_zero <= Op_EX[OP_DIV_BIT] && (Operand_B_EX == '0);
`ifdef MULDIV_SIGNED_EN
            // a zero divisor keeps the all-ones quotient un-negated
            op_signed <= signed_req;
            neg_lo    <= signed_req && (Operand_A_EX[DATA_W-1] ^ Operand_B_EX[DATA_W-1])
                         && !(Op_EX[OP_DIV_BIT] && (Operand_B_EX == '0));
            neg_hi    <= signed_req && Operand_A_EX[DATA_W-1];
`endif
         end else if (step) begin
            count <= (count == LAST) ? '0 : count + 6'd1;
         end
         if (wr_res) begin
            HI_EX <= hi_nxt;
            LO_EX <= lo_nxt;
         end
      end
   end

   assign Busy_EX        = (state != IDLE) && (state != DONE);
   assign Stall_EX       = Busy_EX & (Start_EX | Mf_Req_EX);
   assign Done_EX        = (state == DONE);
   assign Div_By_Zero_EX = Done_EX & div_zero;

endmodule
